fir_mac_sequencer: RTL and testbench

- Upstream controller for one DSP48A1 slice used as a time-multiplexed FIR filter.
- Accepts 18-bit signed samples on a valid/ready stream and keeps a TAPS-deep sample delay line plus a coefficient register file.
- Per accepted sample, issues TAPS coefficient/sample pairs on the slice A/B inputs, with OPMODE lagging one cycle.
- Captures the accumulated slice P, then scales, saturates and emits the result on a valid/ready output stream.

---
 rtl/fir_mac_sequencer_if.sv | 31 +++
 rtl/fir_mac_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample streams, coefficient port and DSP slice signals of the FIR MAC sequencer
interface fir_mac_sequencer_if #(
    parameter int TAPS  = 8,
    parameter int OUT_W = 18
);
    localparam int AW = $clog2(TAPS);

    logic                    S_VALID;
    logic                    S_READY;
    logic signed [17:0]      S_DATA;
    logic                    M_VALID;
    logic                    M_READY;
    logic signed [OUT_W-1:0] M_DATA;
    logic                    COEF_WE;
    logic [AW-1:0]           COEF_ADDR;
    logic signed [17:0]      COEF_WDATA;
    logic signed [17:0]      DSP_A;
    logic signed [17:0]      DSP_B;
    logic [7:0]              DSP_OPMODE;
    logic signed [47:0]      DSP_P;

    modport slave (
        input  S_VALID, S_DATA, M_READY, COEF_WE, COEF_ADDR, COEF_WDATA, DSP_P,
        output S_READY, M_VALID, M_DATA, DSP_A, DSP_B, DSP_OPMODE
    );

    modport master (
        output S_VALID, S_DATA, M_READY, COEF_WE, COEF_ADDR, COEF_WDATA, DSP_P,
        input  S_READY, M_VALID, M_DATA, DSP_A, DSP_B, DSP_OPMODE
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR sequencer driving one DSP48A1 slice
module fir_mac_sequencer #(
    parameter int TAPS    = 8,
    parameter int RES_LAT = 3,
    parameter int SHIFT   = 17,
    parameter int OUT_W   = 18
) (
    input  logic              CLK,
    input  logic              RST_N,
    fir_mac_sequencer_if.slave bus
);
    localparam int AW = $clog2(TAPS);
    localparam int CW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(RES_LAT - 1);
    localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_W - 1));
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AW-1:0]           idx;
    logic [AW-1:0]           idx_inc;
    logic [CW-1:0]           cnt;
    logic signed [17:0]      coef [TAPS];
    logic signed [17:0]      x [TAPS];
    logic                    accept;
    logic                    coef_commit;
    logic                    issue_last;
    logic                    drain_last;
    logic signed [17:0]      coef0_eff;
    logic signed [47:0]      p_shift;
    logic signed [OUT_W-1:0] p_sat;

    assign bus.S_READY = (state == IDLE) && RST_N;
    assign bus.M_VALID = (state == OUT);
    assign accept      = (state == IDLE) && bus.S_VALID;
    assign coef_commit = (state == IDLE) && bus.COEF_WE;
    assign issue_last  = (idx == LAST_IDX);
    assign drain_last  = (cnt == LAST_CNT);
    assign idx_inc     = idx + 1'b1;
    // a coefficient written on the accept edge must already feed the first tap
    assign coef0_eff   = (coef_commit && bus.COEF_ADDR == '0) ? bus.COEF_WDATA : coef[0];

    // scale the accumulated product and clamp it into the output range
    always_comb begin
        p_shift = bus.DSP_P >>> SHIFT;
        p_sat   = p_shift[OUT_W-1:0];
        if (p_shift > SAT_MAX) begin
            p_sat = SAT_MAX[OUT_W-1:0];
        end else if (p_shift < SAT_MIN) begin
            p_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.S_VALID)  state_next = ISSUE;
            ISSUE:   if (issue_last)   state_next = DRAIN;
            DRAIN:   if (drain_last)   state_next = OUT;
            OUT:     if (bus.M_READY)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state, tap index, slice operands, OPMODE (one cycle behind A/B) and result capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            bus.DSP_A      <= '0;
            bus.DSP_B      <= '0;
            bus.DSP_OPMODE <= 8'h00;
            bus.M_DATA     <= '0;
        end else begin
            state          <= state_next;
            bus.DSP_OPMODE <= (state != ISSUE) ? OP_HOLD : ((idx == '0) ? OP_FIRST : OP_ACC);
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx       <= '0;
                        bus.DSP_A <= coef0_eff;
                        bus.DSP_B <= bus.S_DATA;
                    end
                end
                ISSUE: begin
                    if (issue_last) begin
                        cnt       <= '0;
                        bus.DSP_A <= '0;
                        bus.DSP_B <= '0;
                    end else begin
                        idx       <= idx_inc;
                        bus.DSP_A <= coef[idx_inc];
                        bus.DSP_B <= x[idx_inc];
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        bus.M_DATA <= p_sat;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // coefficient register file, writable only while idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_commit && (int'(bus.COEF_ADDR) < TAPS)) begin
            coef[bus.COEF_ADDR] <= bus.COEF_WDATA;
        end
    end

    // sample delay line, shifts once per accepted sample
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (accept) begin
            x[0] <= bus.S_DATA;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    fir_mac_sequencer_if #(.TAPS(4), .OUT_W(18)) b0 ();
    fir_mac_sequencer_if #(.TAPS(4), .OUT_W(18)) b1 ();

    fir_mac_sequencer #(.TAPS(4), .RES_LAT(3), .SHIFT(0), .OUT_W(18)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .bus(b0)
    );
    fir_mac_sequencer #(.TAPS(4), .RES_LAT(3), .SHIFT(17), .OUT_W(18)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(b1)
    );

    logic signed [17:0] s0_a, s0_b, s1_a, s1_b;
    logic signed [47:0] s0_m, s0_p, s1_m, s1_p;
    logic [7:0]         s0_op, s1_op;

    // slice 0 model: A1/B1, M and OPMODE registers feed the P register
    always_ff @(posedge CLK) begin
        s0_a  <= b0.DSP_A;
        s0_b  <= b0.DSP_B;
        s0_op <= b0.DSP_OPMODE;
        s0_m  <= 48'(s0_a) * 48'(s0_b);
        s0_p  <= ((s0_op[1:0] == 2'b01) ? s0_m : 48'sd0) + ((s0_op[3:2] == 2'b10) ? s0_p : 48'sd0);
    end
    assign b0.DSP_P = s0_p;

    // slice 1 model, same pipeline
    always_ff @(posedge CLK) begin
        s1_a  <= b1.DSP_A;
        s1_b  <= b1.DSP_B;
        s1_op <= b1.DSP_OPMODE;
        s1_m  <= 48'(s1_a) * 48'(s1_b);
        s1_p  <= ((s1_op[1:0] == 2'b01) ? s1_m : 48'sd0) + ((s1_op[3:2] == 2'b10) ? s1_p : 48'sd0);
    end
    assign b1.DSP_P = s1_p;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] op_log [16];

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    task automatic write_coef(input logic [1:0] addr, input logic [17:0] data);
        @(negedge CLK);
        b0.COEF_WE = 1'b1; b0.COEF_ADDR = addr; b0.COEF_WDATA = data;
        @(posedge CLK); #1;
        b0.COEF_WE = 1'b0;
    endtask

    task automatic set_coefs(input logic [17:0] c0, input logic [17:0] c1, input logic [17:0] c2, input logic [17:0] c3);
        write_coef(2'd0, c0);
        write_coef(2'd1, c1);
        write_coef(2'd2, c2);
        write_coef(2'd3, c3);
    endtask

    // wmode: 0 none, 1 coefficient write on the accept edge, 2 write during ISSUE
    task automatic run_sample(input logic [17:0] s, input int wmode, input logic [1:0] waddr,
                              input logic [17:0] wdata, output logic [17:0] y, output int lat);
        int n = 0;
        @(negedge CLK);
        while (!b0.S_READY && n < 40) begin @(negedge CLK); n++; end
        if (!b0.S_READY) check("s_ready_timeout", 48'd0, 48'd1);
        b0.S_VALID = 1'b1; b0.S_DATA = s;
        if (wmode == 1) begin b0.COEF_WE = 1'b1; b0.COEF_ADDR = waddr; b0.COEF_WDATA = wdata; end
        @(posedge CLK); #1;
        b0.S_VALID = 1'b0; b0.COEF_WE = 1'b0;
        for (int k = 0; k < 16; k++) op_log[k] = 8'h00;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat < 16) op_log[lat] = b0.DSP_OPMODE;
            if (wmode == 2 && lat == 2) begin b0.COEF_WE = 1'b1; b0.COEF_ADDR = waddr; b0.COEF_WDATA = wdata; end
            if (wmode == 2 && lat == 3) b0.COEF_WE = 1'b0;
        end while (!b0.M_VALID && lat < 40);
        if (!b0.M_VALID) check("m_valid_timeout", 48'd0, 48'd1);
        y = $unsigned(b0.M_DATA);
    endtask

    task automatic run_b1(input logic [17:0] c0, input logic [17:0] s, output logic [17:0] y);
        int n = 0;
        @(negedge CLK);
        b1.COEF_WE = 1'b1; b1.COEF_ADDR = 2'd0; b1.COEF_WDATA = c0;
        b1.S_VALID = 1'b1; b1.S_DATA = s;
        @(posedge CLK); #1;
        b1.COEF_WE = 1'b0; b1.S_VALID = 1'b0;
        do begin @(negedge CLK); n++; end while (!b1.M_VALID && n < 40);
        if (!b1.M_VALID) check("b1_m_valid_timeout", 48'd0, 48'd1);
        y = $unsigned(b1.M_DATA);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [17:0] y;
        logic [17:0] held;
        int          lat;
        logic [17:0] imp_exp [5];

        b0.S_VALID = 0; b0.S_DATA = '0; b0.M_READY = 1; b0.COEF_WE = 0; b0.COEF_ADDR = '0; b0.COEF_WDATA = '0;
        b1.S_VALID = 0; b1.S_DATA = '0; b1.M_READY = 1; b1.COEF_WE = 0; b1.COEF_ADDR = '0; b1.COEF_WDATA = '0;

        // reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_s_ready", 48'(b0.S_READY), 48'd0);
        check("rst_m_valid", 48'(b0.M_VALID), 48'd0);
        check("rst_opmode", 48'(b0.DSP_OPMODE), 48'h00);
        check("rst_dsp_a", 48'($unsigned(b0.DSP_A)), 48'd0);
        check("rst_m_data", 48'($unsigned(b0.M_DATA)), 48'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst_s_ready", 48'(b0.S_READY), 48'd1);
        check("post_rst_opmode", 48'(b0.DSP_OPMODE), 48'h08);

        // scaling by 17 with arithmetic shift on the second instance
        run_b1(18'h10000, 18'd4, y);
        check("shift17_pos", 48'(y), 48'd2);
        run_b1(18'h30000, 18'd3, y);
        check("shift17_neg_floor", 48'(y), 48'h3FFFE);

        // impulse response
        set_coefs(18'd1, 18'd2, 18'd3, 18'd4);
        imp_exp[0] = 18'd1; imp_exp[1] = 18'd2; imp_exp[2] = 18'd3; imp_exp[3] = 18'd4; imp_exp[4] = 18'd0;
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 18'd1 : 18'd0, 0, 2'd0, 18'd0, y, lat);
            check($sformatf("impulse_%0d", i), 48'(y), 48'(imp_exp[i]));
            if (i == 0) check("impulse_latency", 48'(lat), 48'd8);
        end

        // step / accumulate with OPMODE sequence
        run_sample(18'd10, 0, 2'd0, 18'd0, y, lat);
        check("step_10", 48'(y), 48'd10);
        check("step_latency", 48'(lat), 48'd8);
        run_sample(18'd20, 0, 2'd0, 18'd0, y, lat);
        check("step_20", 48'(y), 48'd40);
        check("opmode_c1", 48'(op_log[1]), 48'h08);
        check("opmode_c2", 48'(op_log[2]), 48'h01);
        check("opmode_c3", 48'(op_log[3]), 48'h09);
        check("opmode_c4", 48'(op_log[4]), 48'h09);
        check("opmode_c5", 48'(op_log[5]), 48'h09);
        check("opmode_c6", 48'(op_log[6]), 48'h08);

        // saturation and sign
        set_coefs(18'd131071, 18'd0, 18'd0, 18'd0);
        run_sample(18'd131071, 0, 2'd0, 18'd0, y, lat);
        check("sat_pos", 48'(y), 48'h1FFFF);
        write_coef(2'd0, 18'h3FFFF);
        run_sample(18'd5, 0, 2'd0, 18'd0, y, lat);
        check("neg_five", 48'(y), 48'h3FFFB);
        write_coef(2'd0, 18'h20000);
        run_sample(18'd131071, 0, 2'd0, 18'd0, y, lat);
        check("sat_neg", 48'(y), 48'h20000);

        // backpressure
        write_coef(2'd0, 18'h3FFFF);
        b0.M_READY = 1'b0;
        run_sample(18'd7, 0, 2'd0, 18'd0, y, lat);
        check("bp_value", 48'(y), 48'h3FFF9);
        held = y;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("bp_valid_%0d", i), 48'(b0.M_VALID), 48'd1);
            check($sformatf("bp_data_%0d", i), 48'($unsigned(b0.M_DATA)), 48'(held));
            check($sformatf("bp_s_ready_%0d", i), 48'(b0.S_READY), 48'd0);
        end
        b0.M_READY = 1'b1;
        @(negedge CLK);
        check("bp_release_valid", 48'(b0.M_VALID), 48'd0);
        check("bp_release_s_ready", 48'(b0.S_READY), 48'd1);

        // coefficient write timing
        set_coefs(18'd1, 18'd2, 18'd3, 18'd4);
        for (int i = 0; i < 3; i++) run_sample(18'd0, 0, 2'd0, 18'd0, y, lat);
        run_sample(18'd1, 2, 2'd2, 18'd7, y, lat);
        check("cw_tap0", 48'(y), 48'd1);
        run_sample(18'd0, 0, 2'd0, 18'd0, y, lat);
        check("cw_tap1", 48'(y), 48'd2);
        run_sample(18'd0, 0, 2'd0, 18'd0, y, lat);
        check("cw_issue_write_ignored", 48'(y), 48'd3);
        run_sample(18'd0, 0, 2'd0, 18'd0, y, lat);
        check("cw_tap3", 48'(y), 48'd4);
        run_sample(18'd1, 1, 2'd0, 18'd5, y, lat);
        check("cw_write_on_accept", 48'(y), 48'd5);

        // asynchronous reset in the middle of ISSUE
        @(negedge CLK);
        b0.S_VALID = 1'b1; b0.S_DATA = 18'd3;
        @(posedge CLK); #1;
        b0.S_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_m_valid", 48'(b0.M_VALID), 48'd0);
        check("arst_opmode", 48'(b0.DSP_OPMODE), 48'h00);
        check("arst_dsp_a", 48'($unsigned(b0.DSP_A)), 48'd0);
        check("arst_dsp_b", 48'($unsigned(b0.DSP_B)), 48'd0);
        check("arst_s_ready", 48'(b0.S_READY), 48'd0);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("arst_release_s_ready", 48'(b0.S_READY), 48'd1);
        check("arst_release_m_valid", 48'(b0.M_VALID), 48'd0);
        run_sample(18'd9, 0, 2'd0, 18'd0, y, lat);
        check("arst_coefs_zero", 48'(y), 48'd0);
        set_coefs(18'd0, 18'd1, 18'd1, 18'd1);
        run_sample(18'd2, 0, 2'd0, 18'd0, y, lat);
        check("arst_history_zero", 48'(y), 48'd9);

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
